// File: rtl/matrix_reader.sv
// Reads one matrix slot from the shared BRAM: a 3-word header fetch, a validity check,
// then a row-major element stream through a 2-entry skid buffer with valid/ready backpressure.
module matrix_reader #(
  parameter int BLOCK_SIZE = 1152,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_request,
  output logic                  read_ready,
  input  logic [2:0]            matrix_id,
  output logic                  bram_rd_en,
  output logic [ADDR_WIDTH-1:0] bram_rd_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic                  meta_valid,
  output logic [7:0]            rows,
  output logic [7:0]            cols,
  output logic [0:7][7:0]       matrix_name,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  data_last,
  output logic                  read_done,
  output logic                  read_error
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_CHECK, S_STREAM, S_DONE, S_ERR} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, last_addr_q, last_addr_d;
  logic [1:0]            hdr_cnt_q, hdr_cnt_d, cnt_q, cnt_d;
  logic [7:0]            rows_q, rows_d, cols_q, cols_d;
  logic [0:7][7:0]       name_q, name_d;
  logic                  meta_valid_q, meta_valid_d, ret_q, ret_d;
  logic [15:0]           k_q, k_d, head_q, head_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;

  logic [15:0] total;
  logic [2:0]  occ;
  logic        hdr_ok, pop, stream_on, stream_iss, last_pop;

  assign total      = {8'd0, rows_q} * {8'd0, cols_q};
  assign hdr_ok     = (rows_q != 8'd0) && (cols_q != 8'd0) && (total <= 16'(BLOCK_SIZE - 3));
  assign pop        = (cnt_q != 2'd0) && data_ready;
  assign last_pop   = pop && (head_q == total - 16'd1);
  // Buffer fill after this edge; a new read is allowed only if its word will have a free slot.
  assign occ        = {1'b0, cnt_q} + {2'b0, ret_q} - {2'b0, pop};
  // The first element read goes out during CHECK so the stream starts without a bubble.
  assign stream_on  = (state_q == S_STREAM) || (state_q == S_CHECK && meta_valid_q);
  assign stream_iss = stream_on && (k_q < total) && (occ < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (read_request) state_d = S_HDR;
      S_HDR:    if (hdr_cnt_q == 2'd3) state_d = S_CHECK;
      S_CHECK:  state_d = meta_valid_q ? S_STREAM : S_ERR;
      S_STREAM: if (last_pop) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    read_ready   = (state_q == S_IDLE);
    read_done    = (state_q == S_DONE);
    read_error   = (state_q == S_ERR);
    data_valid   = (cnt_q != 2'd0);
    data_last    = data_valid && (head_q == total - 16'd1);
    bram_rd_en   = 1'b0;
    bram_rd_addr = last_addr_q;
    if (state_q == S_HDR && hdr_cnt_q != 2'd3) begin
      bram_rd_en   = 1'b1;
      bram_rd_addr = base_q + ADDR_WIDTH'(hdr_cnt_q);
    end else if (stream_iss) begin
      bram_rd_en   = 1'b1;
      bram_rd_addr = base_q + ADDR_WIDTH'(3) + ADDR_WIDTH'(k_q);
    end
  end

  always_comb begin
    base_d       = base_q;
    last_addr_d  = bram_rd_en ? bram_rd_addr : last_addr_q;
    hdr_cnt_d    = hdr_cnt_q;
    rows_d       = rows_q;
    cols_d       = cols_q;
    name_d       = name_q;
    meta_valid_d = meta_valid_q;
    ret_d        = stream_iss;
    k_d          = stream_iss ? k_q + 16'd1 : k_q;
    head_d       = pop ? head_q + 16'd1 : head_q;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    cnt_d        = cnt_q;
    case ({ret_q, pop})
      2'b10: begin
        if (cnt_q == 2'd0) buf0_d = bram_dout;
        else               buf1_d = bram_dout;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) buf0_d = bram_dout;
        else begin
          buf0_d = buf1_q;
          buf1_d = bram_dout;
        end
      end
      default: ;
    endcase
    if (state_q == S_IDLE && read_request) begin
      base_d       = ADDR_WIDTH'(matrix_id) * ADDR_WIDTH'(BLOCK_SIZE);
      hdr_cnt_d    = 2'd0;
      meta_valid_d = 1'b0;
      k_d          = 16'd0;
      head_d       = 16'd0;
      cnt_d        = 2'd0;
    end
    // Header words land one cycle after their address, i.e. at hdr_cnt 1..3.
    if (state_q == S_HDR) begin
      hdr_cnt_d = hdr_cnt_q + 2'd1;
      case (hdr_cnt_q)
        2'd1: begin
          rows_d = bram_dout[7:0];
          cols_d = bram_dout[15:8];
        end
        2'd2: for (int i = 0; i < 4; i++) name_d[i] = bram_dout[8*i +: 8];
        2'd3: begin
          for (int i = 0; i < 4; i++) name_d[i+4] = bram_dout[8*i +: 8];
          meta_valid_d = hdr_ok;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q       <= '0;
      last_addr_q  <= '0;
      hdr_cnt_q    <= '0;
      rows_q       <= '0;
      cols_q       <= '0;
      name_q       <= '0;
      meta_valid_q <= 1'b0;
      ret_q        <= 1'b0;
      k_q          <= '0;
      head_q       <= '0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      cnt_q        <= '0;
    end else begin
      base_q       <= base_d;
      last_addr_q  <= last_addr_d;
      hdr_cnt_q    <= hdr_cnt_d;
      rows_q       <= rows_d;
      cols_q       <= cols_d;
      name_q       <= name_d;
      meta_valid_q <= meta_valid_d;
      ret_q        <= ret_d;
      k_q          <= k_d;
      head_q       <= head_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      cnt_q        <= cnt_d;
    end
  end

  assign meta_valid  = meta_valid_q;
  assign rows        = rows_q;
  assign cols        = cols_q;
  assign matrix_name = name_q;
  assign data_out    = buf0_q;

endmodule
